// File: rtl/sonic_rx_page_writer.sv
// RX ring write-side front end: gates blocksync output into the 66-bit ring, counts pages and
// applies back-pressure when the ring is full. Optional drop counter: SONIC_RX_DROP_COUNT_EN.
module sonic_rx_page_writer #(
    parameter int BLOCKS_PER_PAGE = 496,
    parameter int NUM_PAGES       = 32,
    parameter int CNT_W           = 9
) (
    input  logic        wr_clk,
    input  logic        reset,
    input  logic        block_lock,
    input  logic [65:0] data_in,
    input  logic        data_valid,
    input  logic        page_release_tgl,
    output logic [65:0] data_out,
    output logic        wrreq,
    output logic        wrena,
    output logic [5:0]  pages_ready,
    output logic        page_done,
    output logic        overflow,
`ifdef SONIC_RX_DROP_COUNT_EN
    output logic [31:0] drop_count,
`endif
    output logic        release_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FILL     = 2'd1,
        ST_STALL    = 2'd2,
        ST_LOCKLOST = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BLK   = CNT_W'(BLOCKS_PER_PAGE - 1);
    localparam logic [5:0]       PAGES_FULL = 6'(NUM_PAGES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_blk_cnt;
    logic             r_rel_sync1;
    logic             r_rel_sync2;
    logic             r_rel_hist;
    logic             w_rel_pulse;
    logic             w_rel_dec;
    logic             w_rel_err;
    logic             w_accept;
    logic             w_last;
    logic             w_drop;
    logic             w_page_inc;

    // Bring the DMA-side release toggle into wr_clk and edge-detect it
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_rel_sync1 <= 1'b0;
            r_rel_sync2 <= 1'b0;
            r_rel_hist  <= 1'b0;
        end else begin
            r_rel_sync1 <= page_release_tgl;
            r_rel_sync2 <= r_rel_sync1;
            r_rel_hist  <= r_rel_sync2;
        end
    end

    assign w_rel_pulse = r_rel_sync2 ^ r_rel_hist;
    // A release with nothing held is flagged rather than allowed to underflow
    assign w_rel_dec   = w_rel_pulse & (pages_ready != 6'd0);
    assign w_rel_err   = w_rel_pulse & (pages_ready == 6'd0);
    assign w_page_inc  = w_accept & w_last;

    // FSM state register
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle accept/drop qualification
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (block_lock) begin
                    w_state_nxt = ST_FILL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (!block_lock) begin
                    w_state_nxt = ST_LOCKLOST;
                end else begin
                    w_accept = data_valid;
                    w_last   = data_valid & (r_blk_cnt == LAST_BLK);
                    // Stall only if this completion fills the last free page
                    if (w_last && !w_rel_dec && (pages_ready == PAGES_FULL - 6'd1)) begin
                        w_state_nxt = ST_STALL;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end
            ST_STALL: begin
                if (!block_lock) begin
                    w_state_nxt = ST_LOCKLOST;
                end else begin
                    w_drop = data_valid;
                    if (pages_ready < PAGES_FULL) begin
                        w_state_nxt = ST_FILL;
                    end else begin
                        w_state_nxt = ST_STALL;
                    end
                end
            end
            ST_LOCKLOST: begin
                if (!block_lock) begin
                    w_state_nxt = ST_LOCKLOST;
                end else if (pages_ready < PAGES_FULL) begin
                    w_state_nxt = ST_FILL;
                end else begin
                    w_state_nxt = ST_STALL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write path, page accounting and sticky status flags
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_blk_cnt   <= '0;
            data_out    <= 66'd0;
            wrreq       <= 1'b0;
            wrena       <= 1'b0;
            page_done   <= 1'b0;
            pages_ready <= 6'd0;
            overflow    <= 1'b0;
            release_err <= 1'b0;
        end else begin
            wrreq     <= w_accept;
            page_done <= w_page_inc;
            wrena     <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                data_out  <= data_in;
                r_blk_cnt <= w_last ? '0 : r_blk_cnt + 1'b1;
            end else begin
                data_out  <= data_out;
                r_blk_cnt <= r_blk_cnt;
            end
            case ({w_page_inc, w_rel_dec})
                2'b10: begin
                    if (pages_ready < PAGES_FULL) begin
                        pages_ready <= pages_ready + 6'd1;
                    end else begin
                        pages_ready <= pages_ready;
                    end
                end
                2'b01:   pages_ready <= pages_ready - 6'd1;
                default: pages_ready <= pages_ready;
            endcase
            overflow    <= overflow | w_drop;
            release_err <= release_err | w_rel_err;
        end
    end

`ifdef SONIC_RX_DROP_COUNT_EN
    // Saturating count of blocks dropped while the ring is full
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            drop_count <= 32'd0;
        end else if (w_drop && (drop_count != 32'hFFFF_FFFF)) begin
            drop_count <= drop_count + 32'd1;
        end else begin
            drop_count <= drop_count;
        end
    end
`endif

endmodule

// File: tb/tb_sonic_rx_page_writer.sv
// Scoreboard bench for sonic_rx_page_writer: expected writes are queued as blocks are driven
// and checked by a monitor one cycle later; scenario tasks check page accounting and flags.
module tb_sonic_rx_page_writer;

    localparam int BPP = 496;

    logic        wr_clk = 1'b0;
    logic        reset;
    logic        block_lock;
    logic [65:0] data_in;
    logic        data_valid;
    logic        page_release_tgl;
    logic [65:0] data_out;
    logic        wrreq;
    logic        wrena;
    logic [5:0]  pages_ready;
    logic        page_done;
    logic        overflow;
    logic        release_err;
`ifdef SONIC_RX_DROP_COUNT_EN
    logic [31:0] drop_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [66:0] sb_q[$];

    sonic_rx_page_writer dut (
        .wr_clk           (wr_clk),
        .reset            (reset),
        .block_lock       (block_lock),
        .data_in          (data_in),
        .data_valid       (data_valid),
        .page_release_tgl (page_release_tgl),
        .data_out         (data_out),
        .wrreq            (wrreq),
        .wrena            (wrena),
        .pages_ready      (pages_ready),
        .page_done        (page_done),
        .overflow         (overflow),
`ifdef SONIC_RX_DROP_COUNT_EN
        .drop_count       (drop_count),
`endif
        .release_err      (release_err)
    );

    always #5 wr_clk = ~wr_clk;

    // Monitor: every write must match the oldest queued expectation
    always @(posedge wr_clk) begin
        #1;
        if (!reset) begin
            if (wrreq) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wrreq data_out=%h expected no write", data_out);
                end else begin
                    logic [66:0] exp_e;
                    exp_e = sb_q.pop_front();
                    if ({page_done, data_out} !== exp_e) begin
                        errors++;
                        $display("FAIL write page_done/data=%0b/%h expected %0b/%h",
                                 page_done, data_out, exp_e[66], exp_e[65:0]);
                    end
                end
            end else if (page_done) begin
                checks++;
                errors++;
                $display("FAIL page_done_without_wrreq got 1 expected 0");
            end
        end
    end

    task automatic cyc();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send(input logic [65:0] d, input bit exp_wr, input bit exp_done, input bit tgl);
        data_in    = d;
        data_valid = 1'b1;
        if (tgl) page_release_tgl = ~page_release_tgl;
        if (exp_wr) sb_q.push_back({exp_done, d});
        cyc();
    endtask

    function automatic logic [65:0] rnd66();
        return {2'($urandom), $urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset = 1'b1; block_lock = 1'b0; data_in = 66'd0; data_valid = 1'b0;
        page_release_tgl = 1'b0;
        #1;
        checks++;
        if ({data_out, wrreq, wrena, pages_ready, page_done, overflow, release_err} !== 77'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0",
                     {data_out, wrreq, wrena, pages_ready, page_done, overflow, release_err});
        end
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        checks++;
        if (wrena !== 1'b0) begin
            errors++;
            $display("FAIL idle_wrena got %b expected 0", wrena);
        end
    endtask

    task automatic test_basic_fill();
        block_lock = 1'b1;
        cyc();
        checks++;
        if (wrena !== 1'b1) begin
            errors++;
            $display("FAIL fill_wrena got %b expected 1", wrena);
        end
        for (int k = 0; k < BPP; k++) send(66'(k), 1'b1, k == BPP - 1, 1'b0);
        data_valid = 1'b0;
        checks++;
        if (pages_ready !== 6'd1) begin
            errors++;
            $display("FAIL basic_pages got %0d expected 1", pages_ready);
        end
        cyc();
        checks++;
        if (data_out !== 66'd495 || wrreq !== 1'b0) begin
            errors++;
            $display("FAIL data_hold got %h/%b expected 1ef/0", data_out, wrreq);
        end
    endtask

    task automatic test_lock_loss();
        for (int k = 0; k < 200; k++) send(rnd66(), 1'b1, 1'b0, 1'b0);
        data_valid = 1'b0;
        block_lock = 1'b0;
        cyc();
        for (int k = 0; k < 50; k++) send(rnd66(), 1'b0, 1'b0, 1'b0);
        data_valid = 1'b0;
        checks++;
        if (wrena !== 1'b1) begin
            errors++;
            $display("FAIL locklost_wrena got %b expected 1", wrena);
        end
        block_lock = 1'b1;
        cyc();
        for (int k = 0; k < 296; k++) send(rnd66(), 1'b1, k == 295, 1'b0);
        data_valid = 1'b0;
        checks++;
        if (pages_ready !== 6'd2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL lockloss pages/overflow got %0d/%b expected 2/0", pages_ready, overflow);
        end
    endtask

    task automatic test_full_ring();
        for (int p = 0; p < 30; p++)
            for (int k = 0; k < BPP; k++) send(rnd66(), 1'b1, k == BPP - 1, 1'b0);
        checks++;
        if (pages_ready !== 6'd32) begin
            errors++;
            $display("FAIL full_pages got %0d expected 32", pages_ready);
        end
        for (int k = 0; k < 10; k++) send(rnd66(), 1'b0, 1'b0, 1'b0);
        data_valid = 1'b0;
        cyc();
        checks++;
        if (overflow !== 1'b1 || pages_ready !== 6'd32 || wrena !== 1'b1) begin
            errors++;
            $display("FAIL stall overflow/pages/wrena got %b/%0d/%b expected 1/32/1",
                     overflow, pages_ready, wrena);
        end
`ifdef SONIC_RX_DROP_COUNT_EN
        checks++;
        if (drop_count !== 32'd10) begin
            errors++;
            $display("FAIL drop_count got %0d expected 10", drop_count);
        end
`endif
    endtask

    task automatic test_release_from_full();
        page_release_tgl = ~page_release_tgl;
        cyc(); cyc();
        checks++;
        if (pages_ready !== 6'd32) begin
            errors++;
            $display("FAIL release_early got %0d expected 32", pages_ready);
        end
        cyc();
        checks++;
        if (pages_ready !== 6'd31) begin
            errors++;
            $display("FAIL release_latency got %0d expected 31", pages_ready);
        end
        cyc();
        for (int k = 0; k < BPP; k++) send(rnd66(), 1'b1, k == BPP - 1, 1'b0);
        data_valid = 1'b0;
        checks++;
        if (pages_ready !== 6'd32) begin
            errors++;
            $display("FAIL refill_pages got %0d expected 32", pages_ready);
        end
        for (int k = 0; k < 27; k++) begin
            page_release_tgl = ~page_release_tgl;
            cyc(); cyc();
        end
        cyc(); cyc(); cyc(); cyc();
        checks++;
        if (pages_ready !== 6'd5) begin
            errors++;
            $display("FAIL drain_pages got %0d expected 5", pages_ready);
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < BPP; k++) send(rnd66(), 1'b1, k == BPP - 1, k == BPP - 3);
        data_valid = 1'b0;
        checks++;
        if (pages_ready !== 6'd5) begin
            errors++;
            $display("FAIL simul_pages got %0d expected 5", pages_ready);
        end
        cyc(); cyc();
        checks++;
        if (pages_ready !== 6'd5 || release_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_settle pages/rel_err got %0d/%b expected 5/0",
                     pages_ready, release_err);
        end
    endtask

    task automatic test_release_err_and_reset();
        for (int k = 0; k < 100; k++) send(rnd66(), 1'b1, 1'b0, 1'b0);
        data_valid = 1'b0;
        #2;
        reset = 1'b1;
        page_release_tgl = 1'b0;
        #1;
        checks++;
        if ({data_out, wrreq, wrena, pages_ready, page_done, overflow, release_err} !== 77'd0) begin
            errors++;
            $display("FAIL async_reset got %h expected 0",
                     {data_out, wrreq, wrena, pages_ready, page_done, overflow, release_err});
        end
        cyc();
        reset = 1'b0;
        cyc();
        page_release_tgl = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        checks++;
        if (pages_ready !== 6'd0 || release_err !== 1'b1) begin
            errors++;
            $display("FAIL release_err pages/flag got %0d/%b expected 0/1", pages_ready, release_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_lock_loss();
        test_full_ring();
        test_release_from_full();
        test_simultaneous();
        test_release_err_and_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
